// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV32M multiply/divide unit.
// Holds funct3 encodings, the FSM state type and signedness helpers.
package muldiv_pkg;

    localparam int MD_LEN   = 32;
    localparam int MD_CNT_W = $clog2(MD_LEN + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } muldiv_state_t;

    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV)  || (op == OP_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation.
// Used for operand magnitudes and for the final signed result.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide share one 2*LEN register.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int LEN = MD_LEN
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2:0]     op,
    input  logic [LEN-1:0] a,
    input  logic [LEN-1:0] b,
    input  logic           flush,
    output logic [LEN-1:0] result,
    output logic           done,
    output logic           busy,
    output logic           stall
);

    localparam int CW = $clog2(LEN + 1);

    muldiv_state_t    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*LEN-1:0] acc_q, acc_d;
    logic [LEN-1:0]   dvs_q, dvs_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [LEN-1:0]   result_q, result_d;

    logic             sa, sb;
    logic [LEN-1:0]   a_abs, b_abs;
    logic             b_zero, ovf;
    logic [LEN:0]     add_sum, rem_sh, diff;
    logic [2*LEN-1:0] step, fix_in, fix_out;
    logic [LEN-1:0]   res_sel;

    assign sa = a_is_signed(op) & a[LEN-1];
    assign sb = b_is_signed(op) & b[LEN-1];

    muldiv_sign_fix #(.W(LEN)) u_fix_a (
        .val_i (a),
        .neg_i (sa),
        .val_o (a_abs)
    );

    muldiv_sign_fix #(.W(LEN)) u_fix_b (
        .val_i (b),
        .neg_i (sb),
        .val_o (b_abs)
    );

    assign b_zero = (b == '0);
    assign ovf    = ((op == OP_DIV) || (op == OP_REM)) &&
                    (a == {1'b1, {(LEN-1){1'b0}}}) && (b == '1);

    // One multiply or divide iteration on the shared register
    always_comb begin
        add_sum = {1'b0, acc_q[2*LEN-1:LEN]} + {1'b0, dvs_q};
        rem_sh  = acc_q[2*LEN-1:LEN-1];
        diff    = rem_sh - {1'b0, dvs_q};
        step    = acc_q;
        if (state_q == MUL) begin
            if (acc_q[0])
                step = {add_sum, acc_q[LEN-1:1]};
            else
                step = {1'b0, acc_q[2*LEN-1:1]};
        end else begin
            if (diff[LEN])
                step = {rem_sh[LEN-1:0], acc_q[LEN-2:0], 1'b0};
            else
                step = {diff[LEN-1:0], acc_q[LEN-2:0], 1'b1};
        end
    end

    // Pick full product, quotient or remainder before sign correction
    always_comb begin
        if (state_q == MUL)
            fix_in = step;
        else if (op_q[1])
            fix_in = {{LEN{1'b0}}, step[2*LEN-1:LEN]};
        else
            fix_in = {{LEN{1'b0}}, step[LEN-1:0]};
    end

    muldiv_sign_fix #(.W(2*LEN)) u_fix_res (
        .val_i (fix_in),
        .neg_i (neg_q),
        .val_o (fix_out)
    );

    assign res_sel = ((state_q == MUL) && (op_q != OP_MUL)) ?
                     fix_out[2*LEN-1:LEN] : fix_out[LEN-1:0];

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dvs_d    = dvs_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d  = op;
                    cnt_d = '0;
                    neg_d = (op[2] && op[1]) ? sa : (sa ^ sb);
                    if (op[2] && b_zero) begin
                        result_d = op[1] ? a : '1;
                        state_d  = DONE;
                    end else if (ovf) begin
                        result_d = op[1] ? '0 : a;
                        state_d  = DONE;
                    end else begin
                        acc_d   = {{LEN{1'b0}}, a_abs};
                        dvs_d   = b_abs;
                        state_d = op[2] ? DIV : MUL;
                    end
                end
            end
            MUL, DIV: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(LEN - 1)) begin
                    result_d = res_sel;
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            dvs_q    <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dvs_q    <= dvs_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign done   = (state_q == DONE);
    assign busy   = (state_q == MUL) || (state_q == DIV);
    assign stall  = ((state_q == IDLE) && start && !flush) || busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit.
// Checks results, latency, stall length, flush and async reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        stall;

    int n_vec;
    int n_err;

    muldiv_unit #(.LEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .result (result),
        .done   (done),
        .busy   (busy),
        .stall  (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp, input int lat);
        int n;
        int stl;
        @(negedge clk);
        op    = o;
        a     = av;
        b     = bv;
        start = 1'b1;
        #1;
        n   = 0;
        stl = 0;
        while (1) begin
            if (stall) stl++;
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (done || n >= 200) break;
        end
        check({tag, " lat"}, 32'(n), 32'(lat));
        check({tag, " stall"}, 32'(stl), 32'(lat));
        check({tag, " res"}, result, exp);
        @(posedge clk);
        #1;
        check({tag, " done1"}, {31'b0, done}, 32'd0);
        check({tag, " hold"}, result, exp);
    endtask

    initial begin
        int pulses;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = OP_MUL;
        a     = '0;
        b     = '0;
        #12;
        check("rst result", result, 32'd0);
        check("rst done", {31'b0, done}, 32'd0);
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("MUL", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op("MULH", OP_MULH, 32'h80000000, 32'h80000000,
               32'h40000000, 33);
        run_op("MULHU", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 33);
        run_op("MULHSU", OP_MULHSU, 32'hFFFFFFFF, 32'd2,
               32'hFFFFFFFF, 33);
        run_op("DIV", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run_op("REM", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        run_op("DIVU", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("REMU", OP_REMU, 32'd100, 32'd7, 32'd2, 33);

        run_op("DIVovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF,
               32'h80000000, 1);
        run_op("REMovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
        run_op("DIVU0", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        run_op("REM0", OP_REM, 32'd5, 32'd0, 32'd5, 1);

        @(negedge clk);
        op    = OP_DIV;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush busy pre", {31'b0, busy}, 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy", {31'b0, busy}, 32'd0);
        check("flush done", {31'b0, done}, 32'd0);
        check("flush res", result, 32'd5);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("flush nodone", 32'(pulses), 32'd0);
        check("flush res2", result, 32'd5);

        run_op("MUL3x4", OP_MUL, 32'd3, 32'd4, 32'd12, 33);

        @(negedge clk);
        op    = OP_MUL;
        a     = 32'd9;
        b     = 32'd9;
        start = 1'b1;
        flush = 1'b1;
        #1;
        check("fs stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("fs busy", {31'b0, busy}, 32'd0);
        check("fs done", {31'b0, done}, 32'd0);
        check("fs res", result, 32'd12);

        @(negedge clk);
        op    = OP_MUL;
        a     = 32'd5;
        b     = 32'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst busy", {31'b0, busy}, 32'd0);
        check("arst done", {31'b0, done}, 32'd0);
        check("arst res", result, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("DIV9/3", OP_DIV, 32'd9, 32'd3, 32'd3, 33);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage of the pipelined core. It consumes the operands and funct3 held in the ID/EX pipeline register and produces a 32-bit result for the EX/MEM register. While an operation is in flight it raises `stall`, which the hazard logic uses to deassert `en` on the PC, IF/ID and ID/EX registers and to clear EX/MEM.

## Interface
- `LEN`, default 32: operand and result width; the iteration count equals `LEN`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  ID/EX holds a valid M-extension instruction.
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  LEN  rs1 operand.
- `b`  in  LEN  rs2 operand.
- `flush`  in  1  synchronous abort (branch mispredict / trap).
- `result`  out  LEN  registered result.
- `done`  out  1  result valid for exactly one cycle.
- `busy`  out  1  iteration in progress.
- `stall`  out  1  freeze the upstream pipeline registers.

## Operation
- States:
  - IDLE: waiting for `start`.
  - MUL: shift-add multiply, one product bit per cycle.
  - DIV: restoring divide, one quotient bit per cycle.
  - DONE: `result` is valid.
- IDLE with `start` = 1 at a rising edge:
  - Capture |a| and |b| according to the signedness of `op`, plus the result sign flags and `op`.
  - Clear the iteration counter, then enter MUL or DIV.
- Signedness per op:
  - MULH: both operands signed.
  - MULHSU: `a` signed, `b` unsigned.
  - DIV and REM: both operands signed.
  - All other ops: unsigned.
- Fast paths. These go directly IDLE→DONE at the start edge:
  - b == 0: DIV/DIVU give all-ones; REM/REMU give `a`.
  - Signed overflow (DIV/REM with a = 0x80000000, b = -1): DIV gives 0x80000000; REM gives 0.
- MUL/DIV each run exactly `LEN` iterations. At the edge of the last iteration:
  - Apply the sign correction.
  - Select the low or high product half, or the quotient or remainder.
  - Register the value into `result` and enter DONE.
- Sign rules:
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Division truncates toward zero.
- DONE always returns to IDLE on the next edge.
- `result` holds its value until the next DONE.
- `start` while in MUL, DIV or DONE is ignored.
- `flush` = 1 at an edge returns the unit to IDLE from any state.
  - No `done` pulse is produced and `result` keeps its old value.
  - `flush` beats `start` when both are high in the same cycle.
- Reset (`rst` low, asynchronous): state IDLE, counter 0, `result` 0, `done` 0, `busy` 0.
  - `stall` is 0 unless `start` is high in IDLE.
  - Reset mid-operation discards the operation.

## Timing
- Output decode:
  - `busy` = state is MUL or DIV.
  - `done` = state is DONE.
  - `stall` = (IDLE and `start` and not `flush`) or `busy`. This is combinational, so the pipeline freezes in the same cycle `start` appears.
- Normal operation, with start sampled at edge E:
  - Iterations occur at edges E+1 … E+LEN.
  - DONE is entered at edge E+LEN, so `done` is high in the cycle between edges E+LEN and E+LEN+1.
  - `stall` is high from the start cycle through the last MUL/DIV cycle and low during DONE, so EX/MEM captures `result` at edge E+LEN+1.
  - Total: LEN+1 cycles of stall.
- Fast path: DONE is entered at edge E; `stall` is high for one cycle only and `done` is high for one cycle.
- Back-to-back M instructions: the next `start` is accepted in the IDLE cycle after DONE, with no extra bubble.

## Structure
- Package `muldiv_pkg`:
  - funct3 constants `OP_MUL` … `OP_REMU`.
  - State enum `muldiv_state_t` {IDLE, MUL, DIV, DONE}.
  - Counter width `$clog2(LEN+1)`.
- Single module `muldiv_unit`. The 2·LEN product/remainder-quotient shift register is shared between MUL and DIV.
- One natural sub-module, `muldiv_sign_fix`: combinational absolute value on input and negation on output, instantiated for operands and result.

## Test plan
- MUL a=7, b=0xFFFFFFFD (-3) → result 0xFFFFFFEB. `done` in the 33rd cycle after start; `stall` high for 33 cycles.
- MULH a=b=0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV a=-7, b=2 → 0xFFFFFFFD. REM a=-7, b=2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Fast paths:
  - DIVU 5/0 → 0xFFFFFFFF, REM 5/0 → 5, each with a one-cycle stall.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM of the same → 0.
- Flush:
  - Assert `flush` at iteration 10 of a DIV → IDLE next cycle, no `done`, `result` unchanged.
  - A following MUL 3×4 → 12 in the normal 33 cycles.
  - `flush` and `start` in the same cycle → start ignored.
- Drive `rst` low asynchronously mid-MUL → `busy`, `done` and `result` are 0 immediately. After release, DIV 9/3 → 3.
